nasti_dma_mover: RTL and testbench
==================================

NASTI_DMA_MOVER -- requirements
Module: nasti_dma_mover

Interface
- REQ-001 The block SHALL have parameter ADDR_WIDTH, default 64, the byte address and length width.
- REQ-002 The block SHALL have parameter DATA_WIDTH, default 64, the NASTI data width; 8 bytes per beat at the default.
- REQ-003 The block SHALL have parameter MAX_BURST, default 16, the maximum beats per burst and the depth of the internal beat buffer.
- REQ-004 The ports SHALL be, one per line, name, direction, width and meaning:
  - aclk  in  1  clock; all logic on the rising edge.
  - areset  in  1  reset; asynchronous, active-high.
  - dm_en  in  1  one-cycle command strobe from the DMA controller.
  - src_addr  in  ADDR_WIDTH  source byte address.
  - dest_addr  in  ADDR_WIDTH  destination byte address.
  - length  in  ADDR_WIDTH  transfer length in bytes.
  - done  out  1  level; 1 = idle, 0 = transfer in progress.
  - err  out  1  sticky bus-error flag.
  - ar_valid, ar_addr, ar_len  out  1, ADDR_WIDTH, 8  read address channel.
  - ar_ready  in  1  read address accept.
  - r_valid, r_data, r_resp, r_last  in  1, DATA_WIDTH, 2, 1  read data channel.
  - r_ready  out  1  read data accept.
  - aw_valid, aw_addr, aw_len  out  1, ADDR_WIDTH, 8  write address channel.
  - aw_ready  in  1  write address accept.
  - w_valid, w_data, w_strb, w_last  out  1, DATA_WIDTH, DATA_WIDTH/8, 1  write data channel.
  - w_ready  in  1  write data accept.
  - b_valid, b_resp  in  1, 2  write response channel.
  - b_ready  out  1  write response accept.

Function
- REQ-005 The block SHALL sample src_addr, dest_addr and length when dm_en=1 in IDLE, and SHALL drive done=0 from the next cycle; dm_en outside IDLE SHALL be ignored.
- REQ-006 The beat count SHALL be length >> log2(DATA_WIDTH/8); the low length bits and the low address bits SHALL be ignored, so addresses are beat-aligned.
- REQ-007 A zero beat count SHALL generate no bus traffic and SHALL hold done=0 for exactly one cycle.
- REQ-008 The state machine SHALL be IDLE -> RD_ADDR -> RD_DATA -> WR_ADDR -> WR_DATA -> WR_RESP -> (RD_ADDR if beats remain, else IDLE).
- REQ-009 Each chunk SHALL be the minimum of: beats remaining, MAX_BURST, beats to the next 4 KB boundary of the source, and beats to the next 4 KB boundary of the destination.
- REQ-010 ar_len and aw_len SHALL each equal chunk-1.
- REQ-011 Every valid SHALL assert in its state, hold until the matching ready, and keep its address, length and data stable while unaccepted.
- REQ-012 RD_DATA SHALL drive r_ready=1 and store beat k of the chunk into buffer[k].
- REQ-013 RD_DATA SHALL advance after chunk beats, counted by the beat counter, not by r_last.
- REQ-014 WR_DATA SHALL present buffer[k] in order and assert w_last on beat chunk-1 only.
- REQ-015 w_strb SHALL be all ones.
- REQ-016 The write address channel SHALL NOT assert before the last read beat of the same chunk is accepted.
- REQ-017 WR_RESP SHALL drive b_ready=1; on b_valid the block SHALL advance both addresses by chunk*DATA_WIDTH/8 and subtract chunk from the beats remaining.
- REQ-018 done SHALL return to 1 in the cycle after the final B handshake.
- REQ-019 Arithmetic SHALL be modulo 2^ADDR_WIDTH; no address wrap detection is required.

Reset
- REQ-020 areset=1 SHALL immediately force IDLE, done=1, err=0, and every valid, every ready and w_last to 0; the buffer contents are not reset.
- REQ-021 Reset mid-transfer SHALL abandon the transfer with no completion signalled; after release the block SHALL accept a new dm_en.

Configuration
- REQ-022 With NASTI_DMA_MOVER_ERR_EN defined, err SHALL set on any r_resp or b_resp value other than 0 in a handshake, or on r_last not matching beat chunk-1; err SHALL clear only on the next accepted dm_en or on reset; the transfer SHALL still run to completion.
- REQ-023 Without NASTI_DMA_MOVER_ERR_EN, err SHALL be tied 0 and r_resp, b_resp and r_last SHALL be unused.

Verification
- REQ-024 src=0x1000, dest=0x8000, length=64, all readys=1 -> one AR (len=7), 8 R beats, one AW (len=7), 8 W beats with w_last on beat 8 only, one B; data copied in order; done=1 after B.
- REQ-025 length=256 -> two bursts of 16 beats; second burst at ar_addr=0x1080 and aw_addr=0x8080.
- REQ-026 src=0x0FF0, dest=0x2000, length=64 -> bursts of 2 then 6 beats; no burst crosses address 0x1000.
- REQ-027 ar_ready/aw_ready/w_ready held 0 for 5 cycles -> valids and payloads held stable; then completion proceeds with data unchanged.
- REQ-028 With NASTI_DMA_MOVER_ERR_EN: b_resp=2 -> err=1 and done still returns to 1; the next dm_en clears err. Reset asserted during WR_DATA -> w_valid=0 immediately and done=1.

Source files
------------

// File: rtl/nasti_dma_mover.sv
// rtl/nasti_dma_mover.sv - NASTI memory-to-memory burst copy engine
//
// Copies `length` bytes from src_addr to dest_addr. Each chunk is read into
// an internal beat buffer and then written back out. Chunks never cross a
// 4 KB page on either side and never exceed MAX_BURST beats. Addresses and
// length are truncated to whole beats.
//
// Optional feature macro: NASTI_DMA_MOVER_ERR_EN
//   defined   : err is a sticky flag for non-OKAY r_resp/b_resp or a
//               misplaced r_last; it clears on the next accepted dm_en.
//   undefined : err is tied 0 and r_resp, b_resp and r_last are ignored.
//
// Ports
//   aclk, areset                 clock, asynchronous active-high reset
//   dm_en                        one-cycle command strobe (honoured when idle)
//   src_addr, dest_addr, length  command payload (bytes)
//   done                         1 = idle, 0 = transfer in progress
//   err                          sticky bus error flag
//   ar_* / r_*                   NASTI read address / read data channels
//   aw_* / w_* / b_*             NASTI write address / data / response channels

module nasti_dma_mover #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    dm_en,
  input  logic [ADDR_WIDTH-1:0]   src_addr,
  input  logic [ADDR_WIDTH-1:0]   dest_addr,
  input  logic [ADDR_WIDTH-1:0]   length,
  output logic                    done,
  output logic                    err,
  output logic                    ar_valid,
  output logic [ADDR_WIDTH-1:0]   ar_addr,
  output logic [7:0]              ar_len,
  input  logic                    ar_ready,
  input  logic                    r_valid,
  input  logic [DATA_WIDTH-1:0]   r_data,
  input  logic [1:0]              r_resp,
  input  logic                    r_last,
  output logic                    r_ready,
  output logic                    aw_valid,
  output logic [ADDR_WIDTH-1:0]   aw_addr,
  output logic [7:0]              aw_len,
  input  logic                    aw_ready,
  output logic                    w_valid,
  output logic [DATA_WIDTH-1:0]   w_data,
  output logic [DATA_WIDTH/8-1:0] w_strb,
  output logic                    w_last,
  input  logic                    w_ready,
  input  logic                    b_valid,
  input  logic [1:0]              b_resp,
  output logic                    b_ready
);

  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int BEAT_SHIFT = $clog2(BYTES);
  localparam int CW         = $clog2(MAX_BURST + 1);
  localparam int IW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [ADDR_WIDTH-1:0] PAGE_MASK  = ADDR_WIDTH'(4095);
  localparam logic [ADDR_WIDTH-1:0] PAGE_BEATS = ADDR_WIDTH'(4096 >> BEAT_SHIFT);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BYTES - 1));
  localparam logic [ADDR_WIDTH-1:0] MAXB       = ADDR_WIDTH'(MAX_BURST);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   src_q;
  logic [ADDR_WIDTH-1:0]   dst_q;
  logic [ADDR_WIDTH-1:0]   rem_q;
  logic [CW-1:0]           chunk_q;
  logic [CW-1:0]           beat_q;
  logic [DATA_WIDTH-1:0]   buffer [MAX_BURST];

  // Smallest of: beats left, MAX_BURST, beats to the next 4 KB page of
  // either address. Addresses are already beat-aligned here.
  function automatic logic [CW-1:0] calc_chunk(input logic [ADDR_WIDTH-1:0] rem,
                                               input logic [ADDR_WIDTH-1:0] s,
                                               input logic [ADDR_WIDTH-1:0] d);
    logic [ADDR_WIDTH-1:0] m;
    logic [ADDR_WIDTH-1:0] to_s;
    logic [ADDR_WIDTH-1:0] to_d;
    m    = (rem > MAXB) ? MAXB : rem;
    to_s = PAGE_BEATS - ((s & PAGE_MASK) >> BEAT_SHIFT);
    to_d = PAGE_BEATS - ((d & PAGE_MASK) >> BEAT_SHIFT);
    if (to_s < m) m = to_s;
    if (to_d < m) m = to_d;
    return CW'(m);
  endfunction

  // First chunk is sized straight from the command inputs so the AR request
  // can be registered in the same edge that accepts dm_en.
  logic [ADDR_WIDTH-1:0] s_al, d_al, beats;
  logic [CW-1:0]         chunk_first;
  assign s_al        = src_addr & ALIGN_MASK;
  assign d_al        = dest_addr & ALIGN_MASK;
  assign beats       = length >> BEAT_SHIFT;
  assign chunk_first = calc_chunk(beats, s_al, d_al);

  // Follow-on chunk, sized from the post-B address/remaining values.
  logic [ADDR_WIDTH-1:0] step, src_nx, dst_nx, rem_nx;
  logic [CW-1:0]         chunk_nx;
  assign step     = ADDR_WIDTH'(chunk_q) << BEAT_SHIFT;
  assign src_nx   = src_q + step;
  assign dst_nx   = dst_q + step;
  assign rem_nx   = rem_q - ADDR_WIDTH'(chunk_q);
  assign chunk_nx = calc_chunk(rem_nx, src_nx, dst_nx);

  logic [CW-1:0] beat_inc;
  logic          last_beat;
  logic          rd_fire;
  logic          b_fire;
  assign beat_inc  = beat_q + CW'(1);
  assign last_beat = (beat_q == chunk_q - CW'(1));
  assign rd_fire   = (state == RD_DATA) && r_valid && r_ready;
  assign b_fire    = (state == WR_RESP) && b_valid && b_ready;

  assign w_strb = '1;

  // Beat buffer has no reset; contents are only read after being filled.
  always_ff @(posedge aclk) begin
    if (rd_fire) buffer[beat_q[IW-1:0]] <= r_data;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      done     <= 1'b1;
      ar_valid <= 1'b0;
      ar_addr  <= '0;
      ar_len   <= '0;
      r_ready  <= 1'b0;
      aw_valid <= 1'b0;
      aw_addr  <= '0;
      aw_len   <= '0;
      w_valid  <= 1'b0;
      w_data   <= '0;
      w_last   <= 1'b0;
      b_ready  <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      chunk_q  <= '0;
      beat_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b1;
          if (dm_en) begin
            src_q   <= s_al;
            dst_q   <= d_al;
            rem_q   <= beats;
            chunk_q <= chunk_first;
            done    <= 1'b0;
            // A zero-beat command stays in IDLE; done drops for one cycle.
            if (beats != '0) begin
              ar_valid <= 1'b1;
              ar_addr  <= s_al;
              ar_len   <= 8'(chunk_first - CW'(1));
              state    <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (ar_ready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            beat_q   <= '0;
            state    <= RD_DATA;
          end
        end
        RD_DATA: begin
          // Chunk end is taken from the beat counter; r_last only feeds err.
          if (r_valid) begin
            if (last_beat) begin
              r_ready  <= 1'b0;
              aw_valid <= 1'b1;
              aw_addr  <= dst_q;
              aw_len   <= 8'(chunk_q - CW'(1));
              state    <= WR_ADDR;
            end else begin
              beat_q <= beat_inc;
            end
          end
        end
        WR_ADDR: begin
          if (aw_ready) begin
            aw_valid <= 1'b0;
            w_valid  <= 1'b1;
            w_data   <= buffer[0];
            w_last   <= (chunk_q == CW'(1));
            beat_q   <= '0;
            state    <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_ready) begin
            if (w_last) begin
              w_valid <= 1'b0;
              w_last  <= 1'b0;
              b_ready <= 1'b1;
              state   <= WR_RESP;
            end else begin
              beat_q <= beat_inc;
              w_data <= buffer[beat_inc[IW-1:0]];
              w_last <= (beat_inc == chunk_q - CW'(1));
            end
          end
        end
        WR_RESP: begin
          if (b_valid) begin
            b_ready <= 1'b0;
            src_q   <= src_nx;
            dst_q   <= dst_nx;
            rem_q   <= rem_nx;
            if (rem_nx == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              chunk_q  <= chunk_nx;
              ar_valid <= 1'b1;
              ar_addr  <= src_nx;
              ar_len   <= 8'(chunk_nx - CW'(1));
              state    <= RD_ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NASTI_DMA_MOVER_ERR_EN
  logic err_q;
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_q <= 1'b0;
    end else if (state == IDLE && dm_en) begin
      err_q <= 1'b0;
    end else if (rd_fire && (r_resp != 2'b00 || r_last != last_beat)) begin
      err_q <= 1'b1;
    end else if (b_fire && b_resp != 2'b00) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  logic unused_err_inputs;
  assign unused_err_inputs = ^{r_resp, b_resp, r_last, b_fire};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_nasti_dma_mover.sv
// tb/tb_nasti_dma_mover.sv - directed bench for nasti_dma_mover

module tb_nasti_dma_mover;

  logic        aclk;
  logic        areset;
  logic        dm_en;
  logic [63:0] src_addr, dest_addr, length;
  logic        done, err;
  logic        ar_valid;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic        ar_ready;
  logic        r_valid;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        r_ready;
  logic        aw_valid;
  logic [63:0] aw_addr;
  logic [7:0]  aw_len;
  logic        aw_ready;
  logic        w_valid;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic        w_ready;
  logic        b_valid;
  logic [1:0]  b_resp;
  logic        b_ready;

  nasti_dma_mover #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MAX_BURST(16)) dut (
    .aclk(aclk), .areset(areset), .dm_en(dm_en),
    .src_addr(src_addr), .dest_addr(dest_addr), .length(length),
    .done(done), .err(err),
    .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_len(ar_len), .ar_ready(ar_ready),
    .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_ready(r_ready),
    .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_len(aw_len), .aw_ready(aw_ready),
    .w_valid(w_valid), .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_ready(w_ready),
    .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model state and transaction logs
  int          n_ar, n_aw, n_w, n_b;
  logic [63:0] ar_addr_log [8];
  logic [7:0]  ar_len_log  [8];
  logic [63:0] aw_addr_log [8];
  logic [7:0]  aw_len_log  [8];
  logic [63:0] w_data_log  [64];
  logic        w_last_log  [64];
  int          b_cycle;
  int          stable_err, order_err;
  int          stall_ar, stall_aw, stall_w;
  logic [1:0]  bresp_cfg = 2'b00;

  bit          rd_pending, b_pending, r_fire, b_fire, w_done_prev;
  logic [63:0] rd_addr;
  int          rd_left;
  bit          p_ar_hold, p_aw_hold, p_w_hold;
  logic [63:0] p_ar_addr, p_aw_addr, p_w_data;
  logic [7:0]  p_ar_len, p_aw_len;
  logic        p_w_last;

  function automatic logic [63:0] pat(input logic [63:0] a);
    return {~a[31:0], a[31:0]};
  endfunction

  initial begin
    ar_ready = 0; aw_ready = 0; w_ready = 0;
    r_valid = 0; r_data = '0; r_resp = 0; r_last = 0;
    b_valid = 0; b_resp = 0;
    rd_pending = 0; b_pending = 0; r_fire = 0; b_fire = 0; w_done_prev = 0;
    rd_addr = '0; rd_left = 0;
    p_ar_hold = 0; p_aw_hold = 0; p_w_hold = 0;
    stable_err = 0; order_err = 0;
    stall_ar = 0; stall_aw = 0; stall_w = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        rd_pending = 0; b_pending = 0; r_fire = 0; b_fire = 0; w_done_prev = 0;
        p_ar_hold = 0; p_aw_hold = 0; p_w_hold = 0;
        r_valid = 0; b_valid = 0; ar_ready = 0; aw_ready = 0; w_ready = 0;
      end else begin
        if (r_fire) begin
          rd_addr = rd_addr + 64'd8;
          rd_left = rd_left - 1;
          if (rd_left == 0) rd_pending = 0;
        end
        if (b_fire) b_pending = 0;
        if (w_done_prev) b_pending = 1;
        if (p_ar_hold && (!ar_valid || ar_addr !== p_ar_addr || ar_len !== p_ar_len)) stable_err++;
        if (p_aw_hold && (!aw_valid || aw_addr !== p_aw_addr || aw_len !== p_aw_len)) stable_err++;
        if (p_w_hold && (!w_valid || w_data !== p_w_data || w_last !== p_w_last)) stable_err++;
        if (aw_valid && rd_pending) order_err++;

        r_valid = rd_pending;
        r_data  = pat(rd_addr);
        r_last  = (rd_left == 1);
        r_resp  = 2'b00;
        r_fire  = r_valid && r_ready;

        ar_ready = !(ar_valid && stall_ar > 0);
        if (ar_valid && stall_ar > 0) stall_ar--;
        if (ar_valid && ar_ready) begin
          if (n_ar < 8) begin ar_addr_log[n_ar] = ar_addr; ar_len_log[n_ar] = ar_len; end
          n_ar++;
          rd_pending = 1; rd_addr = ar_addr; rd_left = int'(ar_len) + 1;
        end
        p_ar_hold = ar_valid && !ar_ready; p_ar_addr = ar_addr; p_ar_len = ar_len;

        aw_ready = !(aw_valid && stall_aw > 0);
        if (aw_valid && stall_aw > 0) stall_aw--;
        if (aw_valid && aw_ready) begin
          if (n_aw < 8) begin aw_addr_log[n_aw] = aw_addr; aw_len_log[n_aw] = aw_len; end
          n_aw++;
        end
        p_aw_hold = aw_valid && !aw_ready; p_aw_addr = aw_addr; p_aw_len = aw_len;

        w_ready = !(w_valid && stall_w > 0);
        if (w_valid && stall_w > 0) stall_w--;
        w_done_prev = 0;
        if (w_valid && w_ready) begin
          if (n_w < 64) begin w_data_log[n_w] = w_data; w_last_log[n_w] = w_last; end
          n_w++;
          w_done_prev = w_last;
        end
        p_w_hold = w_valid && !w_ready; p_w_data = w_data; p_w_last = w_last;

        b_valid = b_pending;
        b_resp  = bresp_cfg;
        b_fire  = b_valid && b_ready;
        if (b_fire) begin n_b++; b_cycle = cyc; end
      end
    end
  end

  task automatic clear_logs();
    n_ar = 0; n_aw = 0; n_w = 0; n_b = 0; b_cycle = -1;
    stable_err = 0; order_err = 0;
  endtask

  task automatic start_xfer(input logic [63:0] s, input logic [63:0] d, input logic [63:0] l);
    @(negedge aclk);
    src_addr = s; dest_addr = d; length = l; dm_en = 1'b1;
    @(negedge aclk);
    dm_en = 1'b0;
  endtask

  task automatic wait_done(output int done_cyc);
    int i;
    for (i = 0; i < 3000 && done !== 1'b1; i++) @(negedge aclk);
    done_cyc = cyc;
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL done_timeout: done=%b required 1", done); end
  endtask

  task automatic check_data(input string name, input logic [63:0] s, input int nbeats);
    for (int i = 0; i < nbeats && i < 64; i++) begin
      n_checks++;
      if (w_data_log[i] !== pat(s + 64'(i * 8))) begin
        n_fail++;
        $display("FAIL %s_wdata[%0d]: got %h required %h", name, i, w_data_log[i], pat(s + 64'(i * 8)));
      end
    end
  endtask

  task automatic test_reset();
    n_checks++; if (done !== 1'b1)     begin n_fail++; $display("FAIL reset_done: got %b required 1", done); end
    n_checks++; if (err !== 1'b0)      begin n_fail++; $display("FAIL reset_err: got %b required 0", err); end
    n_checks++; if (ar_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ar_valid: got %b required 0", ar_valid); end
    n_checks++; if (aw_valid !== 1'b0) begin n_fail++; $display("FAIL reset_aw_valid: got %b required 0", aw_valid); end
    n_checks++; if (w_valid !== 1'b0 || w_last !== 1'b0) begin n_fail++; $display("FAIL reset_w: got valid=%b last=%b required 0/0", w_valid, w_last); end
    n_checks++; if (r_ready !== 1'b0 || b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_readys: got r=%b b=%b required 0/0", r_ready, b_ready); end
  endtask

  task automatic test_single_burst();
    int dc;
    clear_logs();
    start_xfer(64'h1000, 64'h8000, 64'd64);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_busy: got done=%b required 0", done); end
    wait_done(dc);
    n_checks++; if (n_ar !== 1 || ar_addr_log[0] !== 64'h1000 || ar_len_log[0] !== 8'd7) begin n_fail++; $display("FAIL single_ar: got n=%0d addr=%h len=%0d required 1/1000/7", n_ar, ar_addr_log[0], ar_len_log[0]); end
    n_checks++; if (n_aw !== 1 || aw_addr_log[0] !== 64'h8000 || aw_len_log[0] !== 8'd7) begin n_fail++; $display("FAIL single_aw: got n=%0d addr=%h len=%0d required 1/8000/7", n_aw, aw_addr_log[0], aw_len_log[0]); end
    n_checks++; if (n_w !== 8 || n_b !== 1) begin n_fail++; $display("FAIL single_counts: got w=%0d b=%0d required 8/1", n_w, n_b); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (w_last_log[i] !== (i == 7)) begin n_fail++; $display("FAIL single_wlast[%0d]: got %b required %b", i, w_last_log[i], (i == 7)); end
    end
    check_data("single", 64'h1000, 8);
    n_checks++; if (dc !== b_cycle + 1) begin n_fail++; $display("FAIL single_done_timing: got cycle %0d required %0d", dc, b_cycle + 1); end
    n_checks++; if (order_err !== 0) begin n_fail++; $display("FAIL single_aw_order: got %0d early AW cycles required 0", order_err); end
    n_checks++; if (w_strb !== 8'hFF) begin n_fail++; $display("FAIL w_strb: got %h required ff", w_strb); end
  endtask

  task automatic test_two_bursts();
    int dc;
    clear_logs();
    start_xfer(64'h1000, 64'h8000, 64'd256);
    wait_done(dc);
    n_checks++; if (n_ar !== 2 || ar_addr_log[1] !== 64'h1080 || ar_len_log[0] !== 8'd15 || ar_len_log[1] !== 8'd15) begin n_fail++; $display("FAIL two_ar: got n=%0d addr1=%h len0=%0d len1=%0d required 2/1080/15/15", n_ar, ar_addr_log[1], ar_len_log[0], ar_len_log[1]); end
    n_checks++; if (n_aw !== 2 || aw_addr_log[1] !== 64'h8080 || aw_len_log[1] !== 8'd15) begin n_fail++; $display("FAIL two_aw: got n=%0d addr1=%h len1=%0d required 2/8080/15", n_aw, aw_addr_log[1], aw_len_log[1]); end
    n_checks++; if (n_w !== 32 || n_b !== 2 || w_last_log[15] !== 1'b1 || w_last_log[14] !== 1'b0 || w_last_log[31] !== 1'b1) begin n_fail++; $display("FAIL two_w: got w=%0d b=%0d last14/15/31=%b%b%b required 32/2/011", n_w, n_b, w_last_log[14], w_last_log[15], w_last_log[31]); end
    check_data("two", 64'h1000, 32);
  endtask

  task automatic test_page_split();
    int dc;
    clear_logs();
    start_xfer(64'h0FF0, 64'h2000, 64'd64);
    wait_done(dc);
    n_checks++; if (n_ar !== 2 || ar_addr_log[0] !== 64'h0FF0 || ar_len_log[0] !== 8'd1 || ar_addr_log[1] !== 64'h1000 || ar_len_log[1] !== 8'd5) begin n_fail++; $display("FAIL page_ar: got n=%0d %h/%0d %h/%0d required 2 0ff0/1 1000/5", n_ar, ar_addr_log[0], ar_len_log[0], ar_addr_log[1], ar_len_log[1]); end
    n_checks++; if (n_aw !== 2 || aw_addr_log[0] !== 64'h2000 || aw_len_log[0] !== 8'd1 || aw_addr_log[1] !== 64'h2010 || aw_len_log[1] !== 8'd5) begin n_fail++; $display("FAIL page_aw: got n=%0d %h/%0d %h/%0d required 2 2000/1 2010/5", n_aw, aw_addr_log[0], aw_len_log[0], aw_addr_log[1], aw_len_log[1]); end
    n_checks++; if (n_w !== 8 || w_last_log[1] !== 1'b1 || w_last_log[0] !== 1'b0 || w_last_log[7] !== 1'b1) begin n_fail++; $display("FAIL page_w: got n=%0d last0/1/7=%b%b%b required 8/011", n_w, w_last_log[0], w_last_log[1], w_last_log[7]); end
    check_data("page", 64'h0FF0, 8);
  endtask

  task automatic test_zero_length();
    clear_logs();
    start_xfer(64'h1000, 64'h8000, 64'd7);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got done=%b required 0", done); end
    @(negedge aclk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_one_cycle: got done=%b required 1", done); end
    repeat (4) @(negedge aclk);
    n_checks++; if (n_ar !== 0 || n_aw !== 0 || n_w !== 0) begin n_fail++; $display("FAIL zero_traffic: got ar=%0d aw=%0d w=%0d required 0", n_ar, n_aw, n_w); end
  endtask

  task automatic test_backpressure();
    int dc;
    clear_logs();
    stall_ar = 5; stall_aw = 5; stall_w = 5;
    start_xfer(64'h2000, 64'h9000, 64'd32);
    // New command while busy must be ignored.
    src_addr = 64'h5000; dest_addr = 64'h6000; length = 64'd8; dm_en = 1'b1;
    @(negedge aclk);
    dm_en = 1'b0;
    wait_done(dc);
    repeat (4) @(negedge aclk);
    n_checks++; if (stall_ar !== 0 || stall_aw !== 0 || stall_w !== 0) begin n_fail++; $display("FAIL bp_stalls_used: got %0d/%0d/%0d required 0/0/0", stall_ar, stall_aw, stall_w); end
    n_checks++; if (stable_err !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes required 0", stable_err); end
    n_checks++; if (n_ar !== 1 || ar_addr_log[0] !== 64'h2000 || n_aw !== 1 || aw_addr_log[0] !== 64'h9000) begin n_fail++; $display("FAIL bp_addr: got ar=%0d@%h aw=%0d@%h required 1@2000 1@9000", n_ar, ar_addr_log[0], n_aw, aw_addr_log[0]); end
    n_checks++; if (n_w !== 4 || w_last_log[3] !== 1'b1) begin n_fail++; $display("FAIL bp_w: got n=%0d last3=%b required 4/1", n_w, w_last_log[3]); end
    check_data("bp", 64'h2000, 4);
  endtask

  task automatic test_err_flag();
    int dc;
    clear_logs();
    bresp_cfg = 2'b10;
    start_xfer(64'h3000, 64'h4000, 64'd16);
    wait_done(dc);
    bresp_cfg = 2'b00;
`ifdef NASTI_DMA_MOVER_ERR_EN
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b required 1", err); end
`else
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_tied: got %b required 0", err); end
`endif
    n_checks++; if (n_w !== 2 || n_b !== 1) begin n_fail++; $display("FAIL err_completes: got w=%0d b=%0d required 2/1", n_w, n_b); end
    start_xfer(64'h3000, 64'h4000, 64'd16);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b required 0", err); end
    wait_done(dc);
  endtask

  task automatic test_reset_mid();
    int i;
    int dc;
    clear_logs();
    stall_w = 1000;
    start_xfer(64'h1000, 64'h8000, 64'd64);
    for (i = 0; i < 200 && w_valid !== 1'b1; i++) @(negedge aclk);
    n_checks++; if (w_valid !== 1'b1) begin n_fail++; $display("FAIL rst_reach_wdata: got w_valid=%b required 1", w_valid); end
    #2 areset = 1'b1;
    #1;
    n_checks++; if (w_valid !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL rst_async: got w_valid=%b done=%b required 0/1", w_valid, done); end
    n_checks++; if (aw_valid !== 1'b0 || b_ready !== 1'b0 || w_last !== 1'b0) begin n_fail++; $display("FAIL rst_async_ctrl: got aw=%b b=%b wl=%b required 000", aw_valid, b_ready, w_last); end
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    stall_w = 0;
    n_checks++; if (n_b !== 0) begin n_fail++; $display("FAIL rst_no_b: got %0d required 0", n_b); end
    clear_logs();
    start_xfer(64'h1000, 64'h8000, 64'd16);
    wait_done(dc);
    n_checks++; if (n_w !== 2 || n_b !== 1) begin n_fail++; $display("FAIL rst_restart: got w=%0d b=%0d required 2/1", n_w, n_b); end
    check_data("rst", 64'h1000, 2);
  endtask

  initial begin
    areset = 1'b1; dm_en = 1'b0;
    src_addr = '0; dest_addr = '0; length = '0;
    n_ar = 0; n_aw = 0; n_w = 0; n_b = 0; b_cycle = -1;
    #1;
    test_reset();
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    test_single_burst();
    test_two_bursts();
    test_page_split();
    test_zero_length();
    test_backpressure();
    test_err_flag();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
